// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator and state encodings shared by the calculator core
package calc_pkg;
  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_MUL = 5'h12;
  localparam logic [4:0] KEY_EQ  = 5'h13;
  localparam logic [4:0] KEY_CLR = 5'h14;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [1:0] {ST_RESULT, ST_ENTRY, ST_BUSY} state_t;
  function automatic op_t key_to_op(input logic [4:0] k);
    return k == KEY_ADD ? OP_ADD : k == KEY_SUB ? OP_SUB : k == KEY_MUL ? OP_MUL : OP_NONE;
  endfunction
endpackage

// File: rtl/calc_mult.sv
// calc_mult: sequential shift-add multiplier, one partial product per cycle
module calc_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk5,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  logic [4:0] cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      product <= '0;
      done <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
      done <= 1'b0;
    end else if (start) begin
      cnt <= 5'(WIDTH);
      mcand <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      product <= '0;
      done <= 1'b0;
    end else begin
      // done follows the last iteration so product is already final
      done <= cnt == 5'd1;
      if (cnt != 5'd0) begin
        if (mplier[0]) product <= product + mcand;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - 5'd1;
      end
    end
  end
endmodule

// File: rtl/calc_core.sv
// calc_core: calculator key sequencing, entry/accumulator datapath and display drive
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk5,
  input  logic             reset,
  input  logic             newkey,
  input  logic [4:0]       keycode,
  output logic             busy,
  output logic [WIDTH:0]   dispVal,
  output logic [3:0]       point
);
  state_t st, st_n;
  op_t op, op_n;
  logic [WIDTH-1:0] x, x_n, acc, acc_n;
  logic ovf, ovf_n, start, done;
  logic [2*WIDTH-1:0] product;
  logic is_dig, is_op, is_clr;
  logic [WIDTH:0] sum, dif;
  assign is_dig = newkey && !keycode[4];
  assign is_op  = newkey && keycode >= KEY_ADD && keycode <= KEY_EQ;
  assign is_clr = newkey && keycode == KEY_CLR;
  assign sum = {1'b0, acc} + {1'b0, x};
  assign dif = {1'b0, acc} - {1'b0, x};
  calc_mult #(.WIDTH(WIDTH)) u_mult (
    .clk5(clk5), .reset(reset), .start(start), .abort(is_clr),
    .a(acc), .b(x), .done(done), .product(product)
  );
  always_comb begin
    st_n = st;
    op_n = op;
    x_n = x;
    acc_n = acc;
    ovf_n = ovf;
    start = 1'b0;
    if (st == ST_BUSY) begin
      if (done) begin
        acc_n = product[WIDTH-1:0];
        ovf_n = |product[2*WIDTH-1:WIDTH];
        st_n = ST_RESULT;
      end
    end else if (is_dig) begin
      x_n = st == ST_ENTRY ? {x[WIDTH-5:0], keycode[3:0]} : {{(WIDTH-4){1'b0}}, keycode[3:0]};
      st_n = ST_ENTRY;
    end else if (is_op) begin
      op_n = key_to_op(keycode);
      if (st == ST_ENTRY) begin
        start = op == OP_MUL;
        st_n = op == OP_MUL ? ST_BUSY : ST_RESULT;
        acc_n = op == OP_ADD ? sum[WIDTH-1:0] : op == OP_SUB ? dif[WIDTH-1:0] : op == OP_NONE ? x : acc;
        ovf_n = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? dif[WIDTH] : op == OP_NONE ? 1'b0 : ovf;
      end
    end
  end
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      st <= ST_RESULT;
      op <= OP_NONE;
      x <= '0;
      acc <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
      dispVal <= '0;
      point <= '0;
    end else if (is_clr) begin
      st <= ST_RESULT;
      op <= OP_NONE;
      x <= '0;
      acc <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
      dispVal <= '0;
      point <= '0;
    end else begin
      st <= st_n;
      op <= op_n;
      x <= x_n;
      acc <= acc_n;
      ovf <= ovf_n;
      busy <= st_n == ST_BUSY;
      // the display freezes on the last operand while the multiplier runs
      dispVal <= st_n == ST_BUSY ? dispVal : {ovf_n, st_n == ST_ENTRY ? x_n : acc_n};
      point <= {ovf_n, op_n == OP_MUL, op_n == OP_SUB, op_n == OP_ADD};
    end
  end
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed key sequences against hand-computed display values
module tb_calc_core;
  logic clk5, reset, newkey, busy;
  logic [4:0] keycode;
  logic [16:0] dispVal;
  logic [3:0] point;
  int checks, errors;
  calc_core #(.WIDTH(16)) dut (
    .clk5(clk5), .reset(reset), .newkey(newkey), .keycode(keycode),
    .busy(busy), .dispVal(dispVal), .point(point)
  );
  initial clk5 = 1'b0;
  always #100 clk5 = ~clk5;
  task automatic press(input logic [4:0] k);
    newkey = 1'b1;
    keycode = k;
    @(posedge clk5);
    #1;
    newkey = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    newkey = 1'b0;
    keycode = 5'h0;
    repeat (2) @(posedge clk5);
    #1;
    checks++; if (dispVal !== 17'h0) begin errors++; $display("FAIL reset_disp got=%h exp=%h", dispVal, 17'h0); end
    checks++; if (point !== 4'h0) begin errors++; $display("FAIL reset_point got=%h exp=%h", point, 4'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    @(posedge clk5);
    #1;
  endtask
  task automatic test_entry;
    press(5'h1);
    checks++; if (dispVal !== 17'h00001) begin errors++; $display("FAIL entry1 got=%h exp=%h", dispVal, 17'h00001); end
    press(5'h2);
    press(5'h3);
    press(5'h4);
    checks++; if (dispVal !== 17'h01234) begin errors++; $display("FAIL entry4 got=%h exp=%h", dispVal, 17'h01234); end
    press(5'h5);
    checks++; if (dispVal !== 17'h02345) begin errors++; $display("FAIL entry5 got=%h exp=%h", dispVal, 17'h02345); end
    checks++; if (point !== 4'h0) begin errors++; $display("FAIL entry_point got=%h exp=%h", point, 4'h0); end
    press(5'h14);
  endtask
  task automatic test_add;
    press(5'hA);
    checks++; if (dispVal !== 17'h0000A) begin errors++; $display("FAIL add_a got=%h exp=%h", dispVal, 17'h0000A); end
    press(5'h10);
    checks++; if (point !== 4'h1) begin errors++; $display("FAIL add_point got=%h exp=%h", point, 4'h1); end
    press(5'h7);
    checks++; if (dispVal !== 17'h00007) begin errors++; $display("FAIL add_7 got=%h exp=%h", dispVal, 17'h00007); end
    press(5'h13);
    checks++; if (dispVal !== 17'h00011) begin errors++; $display("FAIL add_eq got=%h exp=%h", dispVal, 17'h00011); end
    checks++; if (point !== 4'h0) begin errors++; $display("FAIL add_eq_point got=%h exp=%h", point, 4'h0); end
    press(5'h14);
  endtask
  task automatic test_sub;
    press(5'h3);
    press(5'h11);
    checks++; if (dispVal !== 17'h00003 || point !== 4'h2) begin errors++; $display("FAIL sub_op got=%h/%h exp=%h/%h", dispVal, point, 17'h00003, 4'h2); end
    press(5'h5);
    press(5'h13);
    checks++; if (dispVal !== 17'h1FFFE) begin errors++; $display("FAIL sub_eq got=%h exp=%h", dispVal, 17'h1FFFE); end
    checks++; if (point !== 4'h8) begin errors++; $display("FAIL sub_point got=%h exp=%h", point, 4'h8); end
    press(5'h14);
    checks++; if (dispVal !== 17'h0 || point !== 4'h0) begin errors++; $display("FAIL clr got=%h/%h exp=0/0", dispVal, point); end
  endtask
  task automatic test_mul;
    int n;
    press(5'h1); press(5'h0); press(5'h0);
    press(5'h12);
    checks++; if (dispVal !== 17'h00100 || point !== 4'h4) begin errors++; $display("FAIL mul_op got=%h/%h exp=%h/%h", dispVal, point, 17'h00100, 4'h4); end
    press(5'h2); press(5'h0); press(5'h0);
    press(5'h13);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_start got=%b exp=1", busy); end
    n = busy ? 1 : 0;
    newkey = 1'b1;
    keycode = 5'h9;
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk5);
      #1;
      if (busy) n++;
      if (i == 5) begin
        checks++; if (dispVal !== 17'h00200) begin errors++; $display("FAIL mul_hold got=%h exp=%h", dispVal, 17'h00200); end
      end
    end
    newkey = 1'b0;
    checks++; if (n != 17) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=17", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end got=%b exp=0", busy); end
    checks++; if (dispVal !== 17'h10000) begin errors++; $display("FAIL mul_result got=%h exp=%h", dispVal, 17'h10000); end
    checks++; if (point !== 4'h8) begin errors++; $display("FAIL mul_point got=%h exp=%h", point, 4'h8); end
    press(5'h14);
  endtask
  task automatic test_reset_mid;
    press(5'h1); press(5'h2);
    press(5'h12);
    press(5'h3);
    press(5'h13);
    repeat (4) @(posedge clk5);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
    #20 reset = 1'b0;
    #10;
    checks++; if (busy !== 1'b0 || dispVal !== 17'h0 || point !== 4'h0) begin errors++; $display("FAIL mid_async got=%b/%h/%h exp=0/0/0", busy, dispVal, point); end
    @(posedge clk5);
    #1 reset = 1'b1;
    press(5'h4);
    checks++; if (dispVal !== 17'h00004 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got=%h/%b exp=%h/0", dispVal, busy, 17'h00004); end
    press(5'h14);
  endtask
  task automatic test_replace;
    press(5'h1);
    press(5'h10);
    press(5'h11);
    checks++; if (point !== 4'h2 || dispVal !== 17'h00001) begin errors++; $display("FAIL repl_op got=%h/%h exp=%h/%h", point, dispVal, 4'h2, 17'h00001); end
    press(5'h2);
    press(5'h13);
    checks++; if (dispVal !== 17'h1FFFF) begin errors++; $display("FAIL repl_eq got=%h exp=%h", dispVal, 17'h1FFFF); end
    press(5'h15);
    press(5'h1F);
    checks++; if (dispVal !== 17'h1FFFF || point !== 4'h8) begin errors++; $display("FAIL unused_key got=%h/%h exp=%h/%h", dispVal, point, 17'h1FFFF, 4'h8); end
    press(5'h14);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_entry;
    test_add;
    test_sub;
    test_mul;
    test_reset_mid;
    test_replace;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
